// File: rtl/filter_pkg.sv
// Shared constants and the sequencer state type for the frame sequencer slice.
package filter_pkg;

    localparam int IMG_W  = 256;
    localparam int IMG_H  = 256;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 16;
    localparam int WDOG_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FILTER = 2'd2,
        ST_UNLOAD = 2'd3
    } state_e;

endpackage

// File: rtl/frame_sequencer_if.sv
// Pixel load stream and result stream of the frame sequencer.
// Both streams: a beat transfers on a rising clk edge where valid and ready are both 1;
// a source holds valid and its payload stable until that beat, and ready may change freely.
interface frame_sequencer_if;
    import filter_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/out_skid_buf.sv
// Two-entry registered output buffer; slot0 is always the head presented downstream.
module out_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         nres,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = slot0_q;
    assign count     = count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            slot0_d = slot1_q;
        end
        // New entry lands behind whatever survives this cycle's pop.
        if (push) begin
            if ((count_q - {1'b0, pop}) == 2'd0) begin
                slot0_d = in_data;
            end else begin
                slot1_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: loads a raster frame into RAM, hands the RAM to a filter
// controller under a watchdog, then streams the filtered frame back out.
module frame_sequencer
    import filter_pkg::*;
#(
    parameter int IMG_W  = filter_pkg::IMG_W,
    parameter int IMG_H  = filter_pkg::IMG_H,
    parameter int WDOG_W = filter_pkg::WDOG_W
) (
    input  logic              clk,
    input  logic              nres,
    input  logic              start,
    frame_sequencer_if.slave  s,
    output logic              filt_start,
    input  logic              filt_done,
    input  logic              filt_rd_en,
    input  logic              filt_wr_en,
    input  logic [ADDR_W-1:0] filt_rd_addr,
    input  logic [ADDR_W-1:0] filt_wr_addr,
    input  logic [PIX_W-1:0]  filt_wr_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [PIX_W-1:0]  ram_rd_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [PIX_W-1:0]  ram_wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              wdog_err,
    output state_e            state_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = {WDOG_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              fstart_q, fstart_d;
    logic              fdone_q, fdone_d;
    logic              rd_all_q, rd_all_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;

    logic              buf_in_ready, buf_valid, buf_pop;
    logic [PIX_W:0]    buf_data;
    logic [1:0]        buf_count;
    logic [2:0]        occ;
    logic              credit_ok;

    out_skid_buf #(.W(PIX_W + 1)) u_out_buf (
        .clk       (clk),
        .nres      (nres),
        .in_valid  (rd_valid_q),
        .in_ready  (buf_in_ready),
        .in_data   ({rd_last_q, ram_rd_data}),
        .out_valid (buf_valid),
        .out_ready (s.out_ready),
        .out_data  (buf_data),
        .count     (buf_count)
    );

    // Occupancy counts the read in flight plus buffered entries left after this cycle's pop,
    // so a drained slot can be refilled at once and streaming holds one pixel per cycle.
    assign buf_pop   = buf_valid & s.out_ready;
    assign occ       = {2'b00, rd_valid_q} + {1'b0, buf_count} - {2'b00, buf_pop};
    assign credit_ok = (occ < 3'd2);

    assign s.out_valid = buf_valid;
    assign s.out_data  = buf_data[PIX_W-1:0];
    assign s.out_last  = buf_valid & buf_data[PIX_W];
    assign filt_start  = fstart_q;
    assign frame_done  = fdone_q;
    assign wdog_err    = err_q;
    assign busy        = (state_q != ST_IDLE);
    assign state_o     = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        rd_all_d    = rd_all_q;
        fstart_d    = 1'b0;
        fdone_d     = 1'b0;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        s.in_ready  = 1'b0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                s.in_ready = 1'b1;
                if (s.in_valid) begin
                    ram_wr_en   = 1'b1;
                    ram_wr_addr = cnt_q;
                    ram_wr_data = s.in_data;
                    if (cnt_q == LAST_ADDR) begin
                        state_d  = ST_FILTER;
                        cnt_d    = '0;
                        wdog_d   = WDOG_W'(1);
                        fstart_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FILTER: begin
                ram_rd_en   = filt_rd_en;
                ram_rd_addr = filt_rd_addr;
                ram_wr_en   = filt_wr_en;
                ram_wr_addr = filt_wr_addr;
                ram_wr_data = filt_wr_data;
                // The watchdog holds the number of FILTER cycles spent, current one included.
                if (filt_done) begin
                    state_d  = ST_UNLOAD;
                    cnt_d    = '0;
                    rd_all_d = 1'b0;
                end else if (wdog_q == WDOG_MAX) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_UNLOAD: begin
                ram_rd_addr = cnt_q;
                if (!rd_all_q && credit_ok && buf_in_ready) begin
                    ram_rd_en  = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (cnt_q == LAST_ADDR);
                    if (cnt_q == LAST_ADDR) begin
                        rd_all_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (buf_pop && buf_data[PIX_W]) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    fdone_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
            fstart_q   <= 1'b0;
            fdone_q    <= 1'b0;
            rd_all_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            fstart_q   <= fstart_d;
            fdone_q    <= fdone_d;
            rd_all_q   <= rd_all_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameters (in filter_pkg), name, default, meaning:
- IMG_W, 256, pixels per line.
- IMG_H, 256, lines per frame.
- PIX_W, 8, pixel width.
- ADDR_W, 16, RAM address width.
- WDOG_W, 18, watchdog counter width.
REQ-002 One clock, clk; reset is asynchronous and active-low, named nres.
REQ-003 Ports, name, direction, width, meaning:
- clk  in  1  clock.
- nres  in  1  async active-low reset.
- start  in  1  frame start pulse.
- in_valid / in_ready  in / out  1 / 1  raster pixel load stream handshake.
- in_data  in  PIX_W  load pixel.
- out_valid / out_ready  out / in  1 / 1  result stream handshake.
- out_data  out  PIX_W  result pixel.
- out_last  out  1  final result pixel.
- filt_start  out  1  one-cycle kick to the filter controller.
- filt_done  in  1  filter controller finished.
- filt_rd_en, filt_wr_en  in  1  filter RAM read / write enables.
- filt_rd_addr, filt_wr_addr  in  ADDR_W  filter RAM read / write addresses.
- filt_wr_data  in  PIX_W  filter RAM write data.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_W  RAM read address.
- ram_rd_data  in  PIX_W  RAM read data, 1-cycle latency.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_W  RAM write address.
- ram_wr_data  out  PIX_W  RAM write data.
- busy  out  1  high when not IDLE.
- frame_done  out  1  one-cycle completion pulse.
- wdog_err  out  1  sticky filter-timeout flag.

Function
REQ-004 States: IDLE, LOAD, FILTER, UNLOAD; the state is registered.
REQ-005 IDLE: start=1 -> LOAD, address counter=0, wdog_err cleared; start is ignored in every other state.
REQ-006 LOAD: in_ready=1; each in_valid&in_ready beat asserts ram_wr_en with ram_wr_addr=counter and ram_wr_data=in_data, combinationally in the same cycle; counter increments per beat.
REQ-007 The beat at counter=IMG_W*IMG_H-1 moves to FILTER, and filt_start=1 for exactly the first FILTER cycle.
REQ-008 FILTER: ram_rd_* and ram_wr_* are combinational pass-through of filt_*; in_ready=0; out_valid=0.
REQ-009 FILTER: filt_done=1 -> UNLOAD with counter=0; filt_done in any other state is ignored.
REQ-010 Watchdog: it counts FILTER cycles; at the all-ones value without filt_done it sets wdog_err=1 and returns to IDLE without frame_done.
REQ-011 UNLOAD: ram_rd_addr=counter; a read issues only when (reads in flight + buffered entries) < 2; counter increments per issued read.
REQ-012 Returned data enters a 2-entry output buffer; out_valid=1 whenever the buffer is non-empty.
REQ-013 out_data and out_last hold stable while out_valid=1 and out_ready=0; out_valid never drops without a handshake.
REQ-014 With out_ready held at 1, throughput is one pixel per cycle after a 2-cycle initial latency from UNLOAD entry.
REQ-015 out_last=1 only with the pixel from address IMG_W*IMG_H-1; its handshake -> IDLE with frame_done=1 for one cycle.
REQ-016 Address counters are ADDR_W bits wide and never wrap inside a state; the terminal compare is exact.
REQ-017 Outside LOAD and FILTER, ram_wr_en=0; outside FILTER and UNLOAD, ram_rd_en=0.

Reset
REQ-018 nres low clears asynchronously: state=IDLE, counters=0, watchdog=0, buffer empty, wdog_err=0.
REQ-019 During reset every output is 0, including in_ready and the ram_* outputs.
REQ-020 nres asserted mid-frame aborts the frame without emitting frame_done; the next frame requires a new start.

Structure
REQ-021 filter_pkg holds IMG_W, IMG_H, PIX_W, ADDR_W, WDOG_W, and the state enum type.
REQ-022 The 2-entry output buffer is one sub-module, out_skid_buf, with valid/ready on both sides.

Verification
REQ-023 Load 65536 pixels with value=addr[7:0] under random in_valid gaps -> 65536 RAM writes at addresses 0..65535; filt_start is a single pulse.
REQ-024 filt_done 100 cycles after filt_start, filter writes forwarded -> ram_* mirrors filt_* exactly during FILTER and is 0 after.
REQ-025 Unload with out_ready toggling 1-0-0-1 -> all 65536 pixels in order, no drops or duplicates, out_last only on the last beat, frame_done one cycle later.
REQ-026 filt_done never asserted -> wdog_err=1 after 2^18-1 FILTER cycles, state IDLE, frame_done stays 0.
REQ-027 nres pulsed at load beat 3000 -> all outputs 0 immediately; start while busy has no effect; a fresh start completes a clean frame.
